// File: rtl/graphics_type_pkg.sv
// Shared vertex/triangle types, screen geometry and the projection sequencer state encoding.
package graphics_type;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int FOCAL    = 800;
   localparam int Z_BIAS   = 400;

   typedef struct packed {
      logic signed [9:0] x;
      logic signed [9:0] y;
      logic signed [9:0] z;
   } vertex_3d_t;

   typedef struct packed {
      logic [9:0]        x;
      logic [8:0]        y;
      logic signed [9:0] z;
   } vertex_2d_t;

   typedef struct packed {
      vertex_3d_t [2:0] v;
   } triangle_3d_t;

   typedef struct packed {
      vertex_2d_t [2:0] v;
   } triangle_2d_t;

   typedef enum logic [2:0] {
      IDLE,
      P0,
      P1,
      P2,
      CHK,
      OUT
   } proj_state_t;

endpackage

// File: rtl/projection_sequencer_projector.sv
// Combinational perspective projector: screen = centre + coord*FOCAL/(z+Z_BIAS), clamped to the screen.
// Zero latency, no handshake; z passes through unchanged.
module projector
   import graphics_type::*;
(
   input  vertex_3d_t v_in,
   output vertex_2d_t v_out
);

   logic signed [11:0] z_ext;
   logic signed [11:0] div_raw;
   logic signed [20:0] div;
   logic signed [20:0] x_ext;
   logic signed [20:0] y_ext;
   logic signed [20:0] num_x;
   logic signed [20:0] num_y;
   logic signed [20:0] s_x;
   logic signed [20:0] s_y;

   always_comb begin
      z_ext   = {{2{v_in.z[9]}}, v_in.z};
      div_raw = z_ext + 12'(Z_BIAS);
      // Out-of-range z only reaches here for near-rejected triangles; keep the divisor legal anyway.
      div     = (div_raw < 12'sd1) ? 21'sd1 : {{9{div_raw[11]}}, div_raw};
      x_ext   = {{11{v_in.x[9]}}, v_in.x};
      y_ext   = {{11{v_in.y[9]}}, v_in.y};
      num_x   = x_ext * 21'(FOCAL);
      num_y   = y_ext * 21'(FOCAL);
      s_x     = (num_x / div) + 21'(SCREEN_W / 2);
      s_y     = (num_y / div) + 21'(SCREEN_H / 2);

      v_out   = '0;
      if (s_x < 21'sd0)
         v_out.x = '0;
      else if (s_x > 21'(SCREEN_W - 1))
         v_out.x = 10'(SCREEN_W - 1);
      else
         v_out.x = s_x[9:0];

      if (s_y < 21'sd0)
         v_out.y = '0;
      else if (s_y > 21'(SCREEN_H - 1))
         v_out.y = 9'(SCREEN_H - 1);
      else
         v_out.y = s_y[8:0];

      v_out.z = v_in.z;
   end

endmodule

// File: rtl/projection_sequencer.sv
// Projects one triangle at a time through a shared projector, then near/backface culls it.
// out_valid 5 cycles after accept; in_ready low outside IDLE, OUT holds until out_ready.
module projection_sequencer
   import graphics_type::*;
#(
   parameter int CNT_W  = 16,
   parameter int NEAR_Z = -399
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  triangle_3d_t       in_tri,
   input  logic               cull_en,
   output logic               out_valid,
   input  logic               out_ready,
   output triangle_2d_t       out_tri,
   output logic [CNT_W-1:0]   cnt_in,
   output logic [CNT_W-1:0]   cnt_out,
   output logic [CNT_W-1:0]   cnt_drop,
   output logic               busy
);

   proj_state_t        state;
   triangle_3d_t       tri_q;
   logic               cull_q;
   logic               near_bad;
   logic               near_in;
   vertex_3d_t         proj_in;
   vertex_2d_t         proj_out;
   logic signed [10:0] dx1;
   logic signed [10:0] dy1;
   logic signed [10:0] dx2;
   logic signed [10:0] dy2;
   logic signed [21:0] prod_a;
   logic signed [21:0] prod_b;
   logic signed [22:0] edge_val;

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   always_comb begin
      near_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (in_tri.v[i].z < NEAR_Z)
            near_in = 1'b1;
      end
   end

   always_comb begin
      case (state)
         P1:      proj_in = tri_q.v[1];
         P2:      proj_in = tri_q.v[2];
         default: proj_in = tri_q.v[0];
      endcase
   end

   projector u_projector (
      .v_in  (proj_in),
      .v_out (proj_out)
   );

   // Screen coords are unsigned; the extra zero bit makes the differences exact in 11-bit signed.
   always_comb begin
      dx1      = $signed({1'b0, out_tri.v[1].x}) - $signed({1'b0, out_tri.v[0].x});
      dx2      = $signed({1'b0, out_tri.v[2].x}) - $signed({1'b0, out_tri.v[0].x});
      dy1      = $signed({2'b00, out_tri.v[1].y}) - $signed({2'b00, out_tri.v[0].y});
      dy2      = $signed({2'b00, out_tri.v[2].y}) - $signed({2'b00, out_tri.v[0].y});
      prod_a   = 22'(dx1) * 22'(dy2);
      prod_b   = 22'(dx2) * 22'(dy1);
      edge_val = 23'(prod_a) - 23'(prod_b);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tri_q     <= '0;
         cull_q    <= 1'b0;
         near_bad  <= 1'b0;
         out_valid <= 1'b0;
         out_tri   <= '0;
         cnt_in    <= '0;
         cnt_out   <= '0;
         cnt_drop  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  tri_q    <= in_tri;
                  cull_q   <= cull_en;
                  near_bad <= near_in;
                  cnt_in   <= cnt_in + CNT_W'(1);
                  state    <= P0;
               end
            end
            P0: begin
               out_tri.v[0] <= proj_out;
               state        <= P1;
            end
            P1: begin
               out_tri.v[1] <= proj_out;
               state        <= P2;
            end
            P2: begin
               if (!near_bad)
                  out_tri.v[2] <= proj_out;
               state <= CHK;
            end
            CHK: begin
               if (near_bad || (cull_q && (edge_val <= 23'sd0))) begin
                  cnt_drop <= cnt_drop + CNT_W'(1);
                  state    <= IDLE;
               end else begin
                  out_valid <= 1'b1;
                  state     <= OUT;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  cnt_out   <= cnt_out + CNT_W'(1);
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
